// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory with valid/ready requests and fixed wait-state latency
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [15:0] busy_cycles
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] LAT = 4'(LATENCY);
  state_t state;
  logic [31:0] mem [2**DEPTH_LOG2];
  logic [3:0] cnt;
  logic we_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0] wdata_q;
  logic [3:0] be_q;
  logic accept;
  logic unused_addr;
  assign accept = req_valid && req_ready;
  assign unused_addr = ^req_addr[31:DEPTH_LOG2];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      busy_cycles <= '0;
      cnt <= '0;
      we_q <= 1'b0;
      idx_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      for (int i = 0; i < 2**DEPTH_LOG2; i++) mem[i] <= '0;
    end else begin
      if (state != IDLE && busy_cycles != 16'hFFFF) busy_cycles <= busy_cycles + 16'd1;
      case (state)
        IDLE: if (accept) begin
          we_q <= req_we;
          idx_q <= req_addr[DEPTH_LOG2-1:0];
          wdata_q <= req_wdata;
          be_q <= req_be;
          req_ready <= 1'b0;
          cnt <= LAT;
          if (LATENCY == 0) begin
            state <= RESP;
            resp_valid <= 1'b1;
            if (!req_we) resp_rdata <= mem[req_addr[DEPTH_LOG2-1:0]];
          end else state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
            resp_valid <= 1'b1;
            if (!we_q) resp_rdata <= mem[idx_q];
          end
        end
        RESP: begin
          state <= IDLE;
          resp_valid <= 1'b0;
          req_ready <= 1'b1;
          // writes commit only on leaving RESP, so a reset mid-flight drops them
          if (we_q)
            for (int b = 0; b < 4; b++)
              if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
